// File: rtl/led_pwm_bank.sv
// Bank of CH_CNT PWM LED channels with double-buffered duty registers.
// Shadow duties are written at any time; active duties swap in only at period boundaries.
module led_pwm_bank #(
  parameter int CLK_FREQ  = 50000000,
  parameter int PWM_FREQ  = 1000,
  parameter int PWM_S_CNT = 200,
  parameter int CH_CNT    = 18
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              wr_valid,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic              period_start,
  output logic [CH_CNT-1:0] LEDR
);

  localparam int               DIV      = CLK_FREQ / (PWM_FREQ * PWM_S_CNT);
  localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [7:0]       S_LAST   = 8'(PWM_S_CNT - 1);
  localparam logic [7:0]       S_MAX    = 8'(PWM_S_CNT);

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       sample;
  logic             ready_q;
  logic [7:0]       shadow [CH_CNT];
  logic [7:0]       active [CH_CNT];

  logic       tick;
  logic       wrap;
  logic       accept;
  logic       addr_ok;
  logic [7:0] duty_in;

  assign tick    = (pre_cnt == PRE_LAST);
  assign wrap    = tick && (sample == S_LAST);
  // The copy cycle refuses writes so a shadow update never races the shadow->active load.
  assign wr_ready = ready_q && !wrap;
  assign accept   = wr_valid && wr_ready;
  assign addr_ok  = (int'(wr_addr) < CH_CNT);
  assign duty_in  = (wr_data > S_MAX) ? S_MAX : wr_data;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pre_cnt      <= '0;
      sample       <= '0;
      ready_q      <= 1'b0;
      wr_err       <= 1'b0;
      period_start <= 1'b0;
      LEDR         <= '0;
      // NOTE: the duty arrays are reset explicitly because a mid-period reset
      // must discard pending shadow writes, not just the counters.
      for (int i = 0; i < CH_CNT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      ready_q      <= 1'b1;
      pre_cnt      <= tick ? '0 : pre_cnt + PRE_W'(1);
      period_start <= wrap;
      wr_err       <= accept && !addr_ok;
      if (tick) begin
        sample <= wrap ? '0 : sample + 8'd1;
      end
      for (int i = 0; i < CH_CNT; i++) begin
        LEDR[i] <= (sample < active[i]);
        if (wrap) begin
          active[i] <= shadow[i];
        end
        if (accept && addr_ok && (wr_addr == 5'(i))) begin
          shadow[i] <= duty_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Randomised bench for led_pwm_bank against a cycle-count based reference model,
// with reduced parameters so several whole PWM periods fit in a short run.
module tb_led_pwm_bank;

  localparam int CLK_FREQ = 65000;
  localparam int PWM_FREQ = 1000;
  localparam int S        = 20;
  localparam int CH       = 18;
  localparam int DIV      = CLK_FREQ / (PWM_FREQ * S);  // 3 (integer division)
  localparam int P        = DIV * S;                    // 60 cycles per period

  logic          CLOCK_50 = 1'b0;
  logic          RESET    = 1'b1;
  logic          wr_valid = 1'b0;
  logic [4:0]    wr_addr  = '0;
  logic [7:0]    wr_data  = '0;
  logic          wr_ready;
  logic          wr_err;
  logic          period_start;
  logic [CH-1:0] LEDR;

  int n_checks = 0;
  int n_fail   = 0;

  led_pwm_bank #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_FREQ (PWM_FREQ),
    .PWM_S_CNT(S),
    .CH_CNT   (CH)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_err      (wr_err),
    .period_start(period_start),
    .LEDR        (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from m_t, the number of clock edges since reset release.
  int            m_t      = 0;
  bit            m_in_rst = 1'b1;
  int            m_shadow [CH];
  int            m_active [CH];
  logic [CH-1:0] m_led    = '0;
  logic          m_err    = 1'b0;
  logic          m_ps     = 1'b0;
  bit            m_acc;
  bit            mon_en   = 1'b0;

  function automatic bit wrap_at(input int tt);
    return (tt % P) == P - 1;
  endfunction

  function automatic int sample_at(input int tt);
    return (tt / DIV) % S;
  endfunction

  function automatic bit m_ready();
    return !m_in_rst && !wrap_at(m_t);
  endfunction

  always @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      m_t      = 0;
      m_in_rst = 1'b1;
      m_led    = '0;
      m_err    = 1'b0;
      m_ps     = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      m_acc = wr_valid && m_ready();
      m_err = m_acc && (int'(wr_addr) >= CH);
      for (int i = 0; i < CH; i++) m_led[i] = (sample_at(m_t) < m_active[i]);
      m_ps = !m_in_rst && wrap_at(m_t);
      if (m_ps) begin
        for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
      end
      if (m_acc && int'(wr_addr) < CH) begin
        m_shadow[wr_addr] = (int'(wr_data) > S) ? S : int'(wr_data);
      end
      m_t      = m_t + 1;
      m_in_rst = 1'b0;
    end
  end

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      check("LEDR", LEDR, m_led);
      check("wr_ready", wr_ready, m_ready());
      check("wr_err", wr_err, m_err);
      check("period_start", period_start, m_ps);
    end
  end

  // Offer a write at a negedge and hold it until a cycle with wr_ready high has passed.
  task automatic do_write(input int addr, input int data, output int waits);
    bit done = 1'b0;
    waits    = 0;
    wr_valid = 1'b1;
    wr_addr  = 5'(addr);
    wr_data  = 8'(data);
    for (int k = 0; k < 8 && !done; k++) begin
      done = wr_ready;
      waits++;
      @(negedge CLOCK_50);
    end
    wr_valid = 1'b0;
    if (!done) check("write_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_ps();
    int k = 0;
    while (!period_start && k < 2 * P + 4) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (!period_start) check("period_start_timeout", 32'(period_start), 32'd1);
  endtask

  // Starting at a period_start cycle, count high cycles of one channel over a full period.
  task automatic count_high(input int ch, output int cnt);
    cnt = 0;
    @(negedge CLOCK_50);
    for (int k = 0; k < P; k++) begin
      if (LEDR[ch]) cnt++;
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    int w;
    int cnt;
    int found;

    repeat (3) @(negedge CLOCK_50);
    mon_en = 1'b1;
    check("reset_LEDR", LEDR, 32'd0);
    check("reset_wr_ready", wr_ready, 32'd0);
    check("reset_period_start", period_start, 32'd0);
    check("reset_wr_err", wr_err, 32'd0);

    RESET = 1'b0;
    check("ready_before_first_edge", wr_ready, 32'd0);
    found = 0;
    for (int k = 1; k <= 3 * P && found == 0; k++) begin
      @(negedge CLOCK_50);
      if (period_start) found = k;
    end
    check("first_period_start_cycle", found, 32'd60);

    // Duty 10 of 20 -> 30 high cycles per 60-cycle period, nothing before the boundary.
    do_write(3, 10, w);
    check("write_single_wait", w, 32'd1);
    check("ch3_before_boundary", LEDR[3], 32'd0);
    wait_ps();
    count_high(3, cnt);
    check("ch3_high_cycles", cnt, 32'd30);

    wait_ps();
    found = 0;
    for (int k = 1; k <= 2 * P && found == 0; k++) begin
      @(negedge CLOCK_50);
      if (period_start) found = k;
    end
    check("period_interval", found, 32'd60);

    // Over-range duty clamps to full scale; then zero gives constant low.
    do_write(0, 250, w);
    wait_ps();
    count_high(0, cnt);
    check("ch0_clamped_full", cnt, 32'd60);
    do_write(0, 0, w);
    wait_ps();
    count_high(0, cnt);
    check("ch0_zero", cnt, 32'd0);

    do_write(20, 77, w);
    check("wr_err_pulse", wr_err, 32'd1);
    @(negedge CLOCK_50);
    check("wr_err_single", wr_err, 32'd0);

    // Present a write exactly on the copy cycle.
    for (int k = 0; k < 2 * P && !wrap_at(m_t); k++) @(negedge CLOCK_50);
    check("boundary_found", 32'(wrap_at(m_t)), 32'd1);
    check("ready_low_at_boundary", wr_ready, 32'd0);
    do_write(7, 9, w);
    check("boundary_write_waits", w, 32'd2);
    wait_ps();
    count_high(7, cnt);
    check("ch7_after_held_write", cnt, 32'd27);

    // Last write in a period wins.
    do_write(5, 5, w);
    do_write(5, 15, w);
    wait_ps();
    count_high(5, cnt);
    check("ch5_last_write_wins", cnt, 32'd45);

    for (int n = 0; n < 150; n++) begin
      do_write(int'($urandom_range(0, 23)), int'($urandom_range(0, 255)), w);
      repeat ($urandom_range(0, 12)) @(negedge CLOCK_50);
    end

    // Mid-period reset with ch3 running and a pending shadow write.
    do_write(3, 10, w);
    wait_ps();
    repeat (P / 3) @(negedge CLOCK_50);
    do_write(3, 18, w);
    #2 RESET = 1'b1;
    #1;
    check("midreset_LEDR_immediate", LEDR, 32'd0);
    check("midreset_ready", wr_ready, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (2 * P + 5) @(negedge CLOCK_50);
    check("after_reset_LEDR_idle", LEDR, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter PWM_FREQ, default 1000, meaning PWM period rate in Hz.
REQ-003 The block SHALL have parameter PWM_S_CNT, default 200, meaning samples (duty steps) per period, at most 255.
REQ-004 The block SHALL have parameter CH_CNT, default 18, meaning channel count, at most 32.
REQ-005 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port wr_valid, input, 1 bit: a duty write is offered.
REQ-008 The block SHALL have port wr_addr, input, 5 bits: channel index of the write.
REQ-009 The block SHALL have port wr_data, input, 8 bits: requested duty in samples.
REQ-010 The block SHALL have port wr_ready, output, 1 bit: the block can accept a write this cycle.
REQ-011 The block SHALL have port wr_err, output, 1 bit: one-cycle pulse when an accepted write had an out-of-range address.
REQ-012 The block SHALL have port period_start, output, 1 bit: one-cycle pulse at each PWM period boundary.
REQ-013 The block SHALL have port LEDR, output, CH_CNT bits: PWM outputs, one bit per channel.

Function
REQ-014 A write SHALL be accepted in any cycle where wr_valid and wr_ready are both high; no other cycle accepts a write.
REQ-015 Prescaler: DIV = CLK_FREQ/(PWM_FREQ*PWM_S_CNT), integer division (250 at defaults); the counter runs 0..DIV-1 and asserts an internal tick in the cycle it equals DIV-1, then wraps to 0.
REQ-016 Sample counter: advances by 1 on each tick, running 0..PWM_S_CNT-1, and wraps to 0 on the tick at PWM_S_CNT-1.
REQ-017 A period boundary SHALL be the cycle in which the sample counter wraps to 0; period_start SHALL be high in the cycle after the wrap, for exactly one cycle.
REQ-018 Each channel SHALL hold a shadow duty register, written by accepted writes, and an active duty register, which drives the output.
REQ-019 An accepted write with wr_addr < CH_CNT SHALL store min(wr_data, PWM_S_CNT) into shadow[wr_addr], visible in the next cycle.
REQ-020 An accepted write with wr_addr >= CH_CNT SHALL change no state and SHALL pulse wr_err in the next cycle.
REQ-021 On a period boundary, all active registers SHALL be loaded from their shadow registers simultaneously; active registers SHALL NOT change at any other time, so no output glitches mid-period.
REQ-022 wr_ready SHALL be low only in a boundary-copy cycle; a write presented then is not accepted and must be held by the source.
REQ-023 LEDR[i] SHALL be registered as (sample counter < active[i]), with one clock of latency after the counter or active register changes.
REQ-024 Duty 0 SHALL give a constant low output; duty = PWM_S_CNT SHALL give a constant high output.
REQ-025 Back-to-back writes to the same channel within one period: the last accepted write wins at the boundary.
REQ-026 Comparisons SHALL be unsigned 8-bit; the sample counter SHALL never exceed PWM_S_CNT-1.

Reset
REQ-027 While RESET is high, the prescaler, sample counter, and all shadow and active registers SHALL be 0, LEDR SHALL be all 0, wr_err and period_start SHALL be 0, and wr_ready SHALL be 0.
REQ-028 After RESET deasserts, wr_ready SHALL be 1 from the first clock edge.
REQ-029 The first tick after reset SHALL occur DIV cycles after release.
REQ-030 Reset asserted mid-period SHALL clear all state immediately, including pending shadow writes; no partial period output is required.

Verification
REQ-031 Defaults: write ch3 = 100 -> LEDR[3] stays 0 until the next boundary, then is high for 100 ticks (25000 cycles) and low for 100 ticks in each 50000-cycle period.
REQ-032 Write ch0 = 250 -> shadow clamps to 200 and LEDR[0] is constantly high after the boundary; write ch0 = 0 -> LEDR[0] is constantly low after the following boundary.
REQ-033 Write wr_addr = 20 -> wr_err pulses once, and LEDR and all duties are unchanged.
REQ-034 Hold wr_valid high across a boundary -> wr_ready is low for exactly that cycle, the write is accepted on the next cycle, and its effect appears one period later.
REQ-035 Write ch5 = 50 then ch5 = 150 within one period -> 150 is applied at the boundary; period_start pulses every 50000 cycles.
REQ-036 Assert RESET mid-period with ch3 active -> LEDR goes to 0 immediately, and after release LEDR remains 0 until new writes are committed at a boundary.
